async_xing_source: RTL and testbench

// - Transmit (source) end of a two-phase toggle clock-domain crossing; the sink end samples with async-reset sync flops.
// - Accepts a payload on a ready/valid port in the local clock domain.
// - Holds the payload stable on xing_data and toggles xing_req once per payload.
// - Waits for the sink's returned xing_ack toggle, synchronised locally, before accepting the next payload.

---
 rtl/async_xing_source.sv | 123 ++++++++++++
 tb/tb_async_xing_source.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_xing_source.sv
// Source (transmit) end of a two-phase toggle clock-domain crossing.
// A payload accepted on the enq ready/valid port is held on xing_data, then
// xing_req toggles once; the next payload is accepted only after the sink's
// xing_ack toggle has been synchronised back and matches xing_req.
// Optional feature: define ASYNC_XING_SOURCE_PARITY_EN to add xing_parity
// (even parity of xing_data, registered alongside it).
module async_xing_source #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             xing_req,
  output logic [WIDTH-1:0] xing_data,
  input  logic             xing_ack,
  output logic             busy
`ifdef ASYNC_XING_SOURCE_PARITY_EN
  ,
  output logic             xing_parity
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_req;
  logic                   w_req_nxt;
  logic [WIDTH-1:0]       r_data;
  logic [WIDTH-1:0]       w_data_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   w_fire;
`ifdef ASYNC_XING_SOURCE_PARITY_EN
  logic                   r_parity;
  logic                   w_parity_nxt;
`endif

  // Ack synchroniser: xing_ack is asynchronous to clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], xing_ack};
    end
  end

  assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
  assign enq_ready = (r_state == S_IDLE) & (w_ack_s == r_req) & reset_n;
  assign w_fire    = enq_valid & enq_ready;

  // State, request toggle and payload registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
    end
  end

`ifdef ASYNC_XING_SOURCE_PARITY_EN
  // Parity register, updated only together with the payload
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_nxt;
    end
  end

  assign xing_parity = r_parity;
`endif

  // Next-state: capture in IDLE, toggle req in LOAD, wait for matching ack
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
`ifdef ASYNC_XING_SOURCE_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_data_nxt  = enq_bits;
`ifdef ASYNC_XING_SOURCE_PARITY_EN
          w_parity_nxt = ^enq_bits;
`endif
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Data has had one full cycle of setup before the req edge
        w_req_nxt   = ~r_req;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_ack_s == r_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign xing_req  = r_req;
  assign xing_data = r_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_async_xing_source.sv
// Self-checking bench for async_xing_source (WIDTH=32, SYNC_STAGES=2).
// A monitor pushes the accepted payload on every fire and pops it when
// xing_req toggles; an optional sink model returns the ack 4 cycles later.
module tb_async_xing_source;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_bits = '0;
  logic        xing_req;
  logic [31:0] xing_data;
  logic        xing_ack = 1'b0;
  logic        busy;
`ifdef ASYNC_XING_SOURCE_PARITY_EN
  logic        xing_parity;
`endif

  int checks = 0;
  int errors = 0;
  int fire_count = 0;
  logic [31:0] exp_q[$];
  logic        req_hist[$];
  logic        prev_req = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_fire = 1'b0;
  logic        sink_en = 1'b0;
  int          sink_cnt = 0;

  async_xing_source #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .xing_req  (xing_req),
    .xing_data (xing_data),
    .xing_ack  (xing_ack),
    .busy      (busy)
`ifdef ASYNC_XING_SOURCE_PARITY_EN
    ,
    .xing_parity (xing_parity)
`endif
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: push on fire, pop and compare on req toggle
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_req  = xing_req;
      prev_data = xing_data;
      prev_fire = 1'b0;
    end else begin
      if (xing_data !== prev_data) begin
        checks++;
        if (!prev_fire) begin
          errors++;
          $display("FAIL data_stable: xing_data changed %h -> %h without fire", prev_data, xing_data);
        end
      end
      if (xing_req !== prev_req) begin
        checks++;
        req_hist.push_back(xing_req);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL req_toggle: req toggled with no payload queued, data %h", xing_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (xing_data !== e) begin
            errors++;
            $display("FAIL req_data: xing_data %h required %h", xing_data, e);
          end
        end
      end
      prev_req  = xing_req;
      prev_data = xing_data;
      prev_fire = enq_valid & enq_ready;
      if (prev_fire) begin
        fire_count++;
        exp_q.push_back(enq_bits);
      end
    end
  end

  // Sink model: returns the req toggle as an ack toggle after 4 cycles
  always begin
    @(posedge clock);
    #1;
    if (sink_en && reset_n) begin
      if (xing_req !== xing_ack) begin
        if (sink_cnt == 3) begin
          xing_ack = xing_req;
          sink_cnt = 0;
        end else begin
          sink_cnt++;
        end
      end else begin
        sink_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    sink_en   = 1'b0;
    enq_valid = 1'b0;
    #2;
    reset_n   = 1'b0;
    xing_ack  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    sink_cnt = 0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (enq_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (enq_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: enq_ready %b required 1", name, enq_ready);
    end
  endtask

  task automatic send(input logic [31:0] v);
    enq_valid = 1'b1;
    enq_bits  = v;
    tick();
    enq_valid = 1'b0;
    enq_bits  = $urandom;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enq_valid = 1'b1;
    enq_bits  = 32'hFFFF_FFFF;
    xing_ack  = 1'b0;
    tick();
    tick();
    checks += 4;
    if (xing_req !== 1'b0) begin errors++; $display("FAIL reset_req: %b required 0", xing_req); end
    if (xing_data !== 32'h0) begin errors++; $display("FAIL reset_data: %h required 0", xing_data); end
    if (enq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: %b required 0", enq_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    enq_valid = 1'b0;
    reset_n   = 1'b1;
    #1;
    checks++;
    if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: %b required 1", enq_ready); end
    tick();
  endtask

  task automatic test_single();
    send(32'hDEAD_BEEF);
    checks += 3;
    if (xing_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: %h required deadbeef", xing_data); end
    if (xing_req !== 1'b0) begin errors++; $display("FAIL single_req_early: %b required 0", xing_req); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: %b required 1", busy); end
    tick();
    checks++;
    if (xing_req !== 1'b1) begin errors++; $display("FAIL single_req: %b required 1", xing_req); end
    xing_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (enq_ready !== (i == 3)) begin
        errors++;
        $display("FAIL single_ack_latency: cycle %0d enq_ready %b required %b", i, enq_ready, (i == 3));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int f0;
    do_reset();
    tick();
    req_hist.delete();
    f0 = fire_count;
    sink_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_ready("b2b");
      send(32'(k));
    end
    wait_ready("b2b_done");
    tick();
    tick();
    checks += 2;
    if (fire_count - f0 !== 3) begin errors++; $display("FAIL b2b_fires: %0d required 3", fire_count - f0); end
    if (req_hist.size() !== 3) begin
      errors++;
      $display("FAIL b2b_toggles: %0d required 3", req_hist.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (req_hist[k] !== ((k % 2) == 0)) begin
          errors++;
          $display("FAIL b2b_req_seq: toggle %0d req %b required %b", k, req_hist[k], ((k % 2) == 0));
        end
      end
    end
    sink_en = 1'b0;
  endtask

  task automatic test_spurious_ack();
    int f0;
    logic [31:0] d0;
    do_reset();
    tick();
    f0 = fire_count;
    d0 = xing_data;
    xing_ack = 1'b1;
    tick();
    tick();
    checks++;
    if (enq_ready !== 1'b0) begin errors++; $display("FAIL spur_ready: %b required 0", enq_ready); end
    enq_valid = 1'b1;
    enq_bits  = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) tick();
    checks += 3;
    if (fire_count !== f0) begin errors++; $display("FAIL spur_fire: %0d fires required 0", fire_count - f0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL spur_busy: %b required 0", busy); end
    if (xing_data !== d0) begin errors++; $display("FAIL spur_data: %h required %h", xing_data, d0); end
    enq_valid = 1'b0;
    xing_ack  = 1'b0;
    tick();
    tick();
    checks++;
    if (enq_ready !== 1'b1) begin errors++; $display("FAIL spur_reenable: %b required 1", enq_ready); end
  endtask

  task automatic test_mid_reset();
    int f0;
    send(32'hA5A5_A5A5);
    tick();
    tick();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_wait: %b required 1", busy); end
    if (xing_req !== 1'b1) begin errors++; $display("FAIL mid_req_wait: %b required 1", xing_req); end
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (xing_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req: %b required 0", xing_req); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: %b required 0", busy); end
    if (xing_data !== 32'h0) begin errors++; $display("FAIL mid_reset_data: %h required 0", xing_data); end
    tick();
    reset_n = 1'b1;
    tick();
    f0 = fire_count;
    sink_en = 1'b1;
    wait_ready("mid");
    send(32'h1234_5678);
    wait_ready("mid_done");
    tick();
    checks += 2;
    if (fire_count - f0 !== 1) begin errors++; $display("FAIL mid_fresh_fire: %0d required 1", fire_count - f0); end
    if (xing_req !== 1'b1) begin errors++; $display("FAIL mid_fresh_req: %b required 1", xing_req); end
    sink_en = 1'b0;
  endtask

`ifdef ASYNC_XING_SOURCE_PARITY_EN
  task automatic test_parity();
    sink_en = 1'b1;
    wait_ready("par");
    send(32'h0000_0007);
    checks += 2;
    if (xing_data !== 32'h7) begin errors++; $display("FAIL par_data7: %h required 7", xing_data); end
    if (xing_parity !== 1'b1) begin errors++; $display("FAIL par_7: %b required 1", xing_parity); end
    wait_ready("par2");
    send(32'h0000_0003);
    checks++;
    if (xing_parity !== 1'b0) begin errors++; $display("FAIL par_3: %b required 0", xing_parity); end
    wait_ready("par_done");
    sink_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_spurious_ack();
    test_mid_reset();
`ifdef ASYNC_XING_SOURCE_PARITY_EN
    test_parity();
`endif
    tick();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
